ftseg_scan_ctrl: RTL and testbench
==================================

Name: ftseg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit 14-segment display. It holds four 4-bit display codes and cycles through them one digit at a time. For the active digit it drives the code onto the display decoder's input and asserts that digit's active-low enable. New display contents are taken through a load/busy handshake and applied only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot (minimum 2)
CNT_W, 16, prescaler width; must satisfy 2^CNT_W >= SCAN_DIV

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
load  input  1  one-cycle strobe; captures digits_in/blank_in into the pending buffer
digits_in  input  16  display codes; [3:0]=digit0 (rightmost) ... [15:12]=digit3
blank_in  input  4  per-digit blank mask; 1 = digit dark
busy  output  1  pending buffer holds contents not yet applied
frame_done  output  1  one-cycle pulse at each digit3->digit0 wrap
bcd  output  4  code for the active digit; feeds the 14-segment decoder
ssd_ctl  output  4  active-low digit enables; [0]=digit0

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. Every flop clears immediately on rst=1, independent of clk.
- Reset values:
  - prescaler = 0, sel = 0
  - active digits = 0, active blank = 4'b1111
  - pending = 0, pend_valid = 0
  - busy = 0, frame_done = 0
  - ssd_ctl = 4'b1111, bcd = 4'd15
  - Result: the display is dark until the first load takes effect.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - tick = (prescaler == SCAN_DIV-1).
- Digit select:
  - sel (2 bits) advances by 1 on tick.
  - Wraps 3->0. The tick with sel==3 is the frame boundary.
- Output register (bcd, ssd_ctl are registered; updated every clock from current sel and active state, so they lag sel by exactly one cycle):
  - Unblanked digit: ssd_ctl = ~(4'b0001 << sel), bcd = active digit[sel].
  - Blanked digit: ssd_ctl = 4'b1111, bcd = 4'd15.
  - Codes are passed through unmodified. 0-9 are digits; 10=A, 11=M, 12='-', 13=P; 14 and 15 decode to all segments off.
- Load handshake:
  - load=1 writes digits_in/blank_in into pending and sets pend_valid.
  - A load while pend_valid=1 overwrites pending (latest wins). No error is flagged.
  - busy = pend_valid (registered).
- Frame boundary tick:
  - If pend_valid=1: active <= pending and pend_valid clears on the same edge. The new contents appear from the digit0 slot onward.
  - If pend_valid=0: active is unchanged.
  - frame_done pulses for one cycle on the edge after every boundary tick, whether or not an update occurred.
- Simultaneous load and boundary tick:
  - active takes the previous pending contents, if pend_valid was set.
  - The incoming load becomes the new pending and pend_valid ends at 1.
  - The new load is therefore applied at the next boundary, never mid-frame.
- Reset mid-operation: all state returns to reset values asynchronously. Pending contents are discarded; scanning restarts from digit0 after rst falls.
- Frame period = 4*SCAN_DIV cycles. Worst-case load-to-display latency = 4*SCAN_DIV + 2 cycles.

Decomposition:
- Shared display package holds:
  - code constants: CODE_A=10, CODE_M=11, CODE_DASH=12, CODE_P=13, CODE_BLANK=15
  - SSD_OFF = 4'b1111
  - NUM_DIGITS = 4
- Sub-module: ftseg_scan_prescaler, containing the SCAN_DIV counter and the tick output. All other logic stays in the top module.
- The 14-segment decoder is instantiated by the parent, not inside this block.

Test Plan:
1. Reset, then run 3 frames with SCAN_DIV=4 and no load -> ssd_ctl=4'b1111, bcd=15 throughout; frame_done pulses every 16 cycles; busy=0.
2. load with digits_in=16'h4321, blank_in=4'b0000 -> busy=1 until the next boundary. Following frame shows (ssd_ctl, bcd) = (1110, 1), (1101, 2), (1011, 3), (0111, 4), each held 4 cycles; busy=0 after the boundary.
3. load with digits_in=16'hDBAC, blank_in=4'b1000 -> slots 0-2 show codes 12, 10, 11 with ssd_ctl 1110, 1101, 1011; slot 3 shows ssd_ctl=1111, bcd=15.
4. Two loads (16'h1111, then 16'h2222) in the same frame -> next frame shows only 2s; no frame ever shows 1s.
5. load 16'h5555 on the exact boundary-tick cycle while pend_valid=0 -> busy stays 1; current frame keeps the old contents; 5s appear one frame later.
6. Assert rst for 1 cycle mid-slot (sel=2, pending valid) -> ssd_ctl=1111, bcd=15, busy=0 before the next clk edge; after release, scan restarts at digit0 with the display dark.

Source files
------------

// File: rtl/ftseg_scan_ctrl_pkg.sv
// ftseg_scan_ctrl_pkg
// Shared display definitions for the 4-digit 14-segment scan controller:
// code constants understood by the segment decoder, the "all digits off"
// enable pattern, the digit count, and a helper mapping a digit select
// to its active-low enable pattern.
package ftseg_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] CODE_A     = 4'd10;
  localparam logic [3:0] CODE_M     = 4'd11;
  localparam logic [3:0] CODE_DASH  = 4'd12;
  localparam logic [3:0] CODE_P     = 4'd13;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  localparam logic [3:0] SSD_OFF = 4'b1111;

  typedef logic [1:0] sel_t;

  // Active-low one-hot enable for the selected digit.
  function automatic logic [3:0] digit_enable(input sel_t sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/ftseg_scan_ctrl_if.sv
// ftseg_scan_ctrl_if
// Load handshake and display outputs of the scan controller.
//   load       : one-cycle strobe capturing digits_in/blank_in
//   digits_in  : four 4-bit codes, [3:0] = digit0 (rightmost)
//   blank_in   : per-digit blank mask, 1 = digit dark
//   busy       : new contents pending, not yet on the display
//   frame_done : one-cycle pulse after each digit3->digit0 wrap
//   bcd        : code of the active digit, to the segment decoder
//   ssd_ctl    : active-low digit enables, [0] = digit0
// master = the block supplying display contents; slave = the controller.
interface ftseg_scan_ctrl_if;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  blank_in;
  logic        busy;
  logic        frame_done;
  logic [3:0]  bcd;
  logic [3:0]  ssd_ctl;

  modport master (
    output load, digits_in, blank_in,
    input  busy, frame_done, bcd, ssd_ctl
  );

  modport slave (
    input  load, digits_in, blank_in,
    output busy, frame_done, bcd, ssd_ctl
  );
endinterface

// File: rtl/ftseg_scan_ctrl_prescaler.sv
// ftseg_scan_prescaler
// Digit-slot prescaler: counts 0..SCAN_DIV-1 and wraps; tick is high
// during the last count of each slot.
//   clk, rst : clock, asynchronous active-high reset
//   tick     : high while the counter sits at SCAN_DIV-1
module ftseg_scan_prescaler #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_p0 <= '0;
    else if (cnt_p0 == LAST)
      cnt_p0 <= '0;
    else
      cnt_p0 <= cnt_p0 + CNT_W'(1);
  end

  assign tick = (cnt_p0 == LAST);

endmodule

// File: rtl/ftseg_scan_ctrl.sv
// ftseg_scan_ctrl
// Time-multiplexed scan controller for a 4-digit 14-segment display.
// Holds the active display contents plus one pending buffer; pending
// contents are promoted to active only at the digit3->digit0 wrap so a
// frame never mixes old and new digits.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of ftseg_scan_ctrl_if (load/busy handshake,
//              frame_done pulse, registered bcd/ssd_ctl outputs)
module ftseg_scan_ctrl
  import ftseg_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  ftseg_scan_ctrl_if.slave   bus
);

  logic        tick;
  logic        boundary;
  sel_t        sel_p0;

  logic [15:0] act_digits;
  logic [3:0]  act_blank;
  logic [15:0] pend_digits;
  logic [3:0]  pend_blank;
  logic        pend_valid;
  logic        frame_done_p1;

  logic [3:0]  cur_code;
  logic        cur_blank;
  logic [3:0]  bcd_p1;
  logic [3:0]  ssd_p1;

  ftseg_scan_prescaler #(
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // The tick that ends the digit3 slot is the frame boundary.
  assign boundary = tick && (sel_p0 == 2'd3);

  // ---- stage p0: digit select ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sel_p0 <= '0;
    else if (tick)
      sel_p0 <= sel_p0 + 2'd1;
  end

  // Pending/active buffers. On a boundary coinciding with a load, active
  // takes the old pending contents (read before this edge) while the new
  // load lands in pending, so it waits a full frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_digits    <= '0;
      act_blank     <= 4'b1111;
      pend_digits   <= '0;
      pend_blank    <= '0;
      pend_valid    <= 1'b0;
      frame_done_p1 <= 1'b0;
    end else begin
      if (boundary && pend_valid) begin
        act_digits <= pend_digits;
        act_blank  <= pend_blank;
      end
      if (bus.load) begin
        pend_digits <= bus.digits_in;
        pend_blank  <= bus.blank_in;
        pend_valid  <= 1'b1;
      end else if (boundary) begin
        pend_valid <= 1'b0;
      end
      frame_done_p1 <= boundary;
    end
  end

  always_comb begin
    cur_code  = act_digits[{sel_p0, 2'b00} +: 4];
    cur_blank = act_blank[sel_p0];
  end

  // ---- stage p1: registered display outputs (one cycle behind sel) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ssd_p1 <= SSD_OFF;
      bcd_p1 <= CODE_BLANK;
    end else if (cur_blank) begin
      ssd_p1 <= SSD_OFF;
      bcd_p1 <= CODE_BLANK;
    end else begin
      ssd_p1 <= digit_enable(sel_p0);
      bcd_p1 <= cur_code;
    end
  end

  assign bus.busy       = pend_valid;
  assign bus.frame_done = frame_done_p1;
  assign bus.bcd        = bcd_p1;
  assign bus.ssd_ctl    = ssd_p1;

endmodule

// File: tb/tb_ftseg_scan_ctrl.sv
// tb_ftseg_scan_ctrl
// Bench for ftseg_scan_ctrl with SCAN_DIV=4 (16-cycle frames). Cycle k
// counts clock edges since reset release; outputs are sampled on the
// falling edge after edge k. Loads in the vector table are sampled by
// the DUT on edge k.
module tb_ftseg_scan_ctrl;
  import ftseg_scan_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ftseg_scan_ctrl_if bus();

  ftseg_scan_ctrl #(
    .SCAN_DIV (4),
    .CNT_W    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          k;
    logic        ld;
    logic [15:0] dig;
    logic [3:0]  blk;
    logic [3:0]  ssd;
    logic [3:0]  bcd;
    logic        busy;
    logic        fd;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   k = 0;
  int   ones_seen = 0;
  logic mon_en = 1'b0;

  function automatic void addv(input int kk, input logic ld, input logic [15:0] dig,
                               input logic [3:0] blk, input logic [3:0] ssd,
                               input logic [3:0] bcd, input logic bz, input logic fd);
    vec_t v;
    v.k = kk; v.ld = ld; v.dig = dig; v.blk = blk;
    v.ssd = ssd; v.bcd = bcd; v.busy = bz; v.fd = fd;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @k=%0d: got %0h, want %0h", name, k, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] ssd, input logic [3:0] bcd,
                           input logic bz, input logic fd);
    chk({tag, ".ssd_ctl"}, 16'(bus.ssd_ctl), 16'(ssd));
    chk({tag, ".bcd"}, 16'(bus.bcd), 16'(bcd));
    chk({tag, ".busy"}, 16'(bus.busy), 16'(bz));
    chk({tag, ".frame_done"}, 16'(bus.frame_done), 16'(fd));
  endtask

  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] b);
    bus.load      = ld;
    bus.digits_in = d;
    bus.blank_in  = b;
    @(posedge clk);
    k++;
    @(negedge clk);
    bus.load = 1'b0;
    if (mon_en && bus.bcd == 4'd1) ones_seen++;
  endtask

  initial begin
    // Vector table: {k, load, digits, blank, exp ssd, exp bcd, exp busy, exp frame_done}
    // 4321 loaded mid frame 3, shown in frame 4
    addv(50,  1, 16'h4321, 4'b0000, SSD_OFF, CODE_BLANK, 1, 0);
    addv(63,  0, 16'h0,    4'b0000, SSD_OFF, CODE_BLANK, 1, 0);
    addv(64,  0, 16'h0,    4'b0000, SSD_OFF, CODE_BLANK, 0, 1);
    addv(65,  0, 16'h0,    4'b0000, 4'b1110, 4'd1, 0, 0);
    addv(68,  0, 16'h0,    4'b0000, 4'b1110, 4'd1, 0, 0);
    addv(69,  0, 16'h0,    4'b0000, 4'b1101, 4'd2, 0, 0);
    // DBAC with digit3 blanked, shown in frame 5
    addv(70,  1, 16'hDBAC, 4'b1000, 4'b1101, 4'd2, 1, 0);
    addv(73,  0, 16'h0,    4'b0000, 4'b1011, 4'd3, 1, 0);
    addv(77,  0, 16'h0,    4'b0000, 4'b0111, 4'd4, 1, 0);
    addv(80,  0, 16'h0,    4'b0000, 4'b0111, 4'd4, 0, 1);
    addv(81,  0, 16'h0,    4'b0000, 4'b1110, CODE_DASH, 0, 0);
    addv(85,  0, 16'h0,    4'b0000, 4'b1101, CODE_A, 0, 0);
    addv(89,  0, 16'h0,    4'b0000, 4'b1011, CODE_M, 0, 0);
    addv(93,  0, 16'h0,    4'b0000, SSD_OFF, CODE_BLANK, 0, 0);
    addv(96,  0, 16'h0,    4'b0000, SSD_OFF, CODE_BLANK, 0, 1);
    // two loads in frame 6: only 2222 reaches frame 7
    addv(97,  0, 16'h0,    4'b0000, 4'b1110, CODE_DASH, 0, 0);
    addv(100, 1, 16'h1111, 4'b0000, 4'b1110, CODE_DASH, 1, 0);
    addv(104, 1, 16'h2222, 4'b0000, 4'b1101, CODE_A, 1, 0);
    addv(111, 0, 16'h0,    4'b0000, SSD_OFF, CODE_BLANK, 1, 0);
    addv(112, 0, 16'h0,    4'b0000, SSD_OFF, CODE_BLANK, 0, 1);
    addv(113, 0, 16'h0,    4'b0000, 4'b1110, 4'd2, 0, 0);
    addv(117, 0, 16'h0,    4'b0000, 4'b1101, 4'd2, 0, 0);
    addv(121, 0, 16'h0,    4'b0000, 4'b1011, 4'd2, 0, 0);
    addv(125, 0, 16'h0,    4'b0000, 4'b0111, 4'd2, 0, 0);
    // 5555 loaded on the boundary edge with nothing pending: frame 8 keeps 2s
    addv(128, 1, 16'h5555, 4'b0000, 4'b0111, 4'd2, 1, 1);
    addv(129, 0, 16'h0,    4'b0000, 4'b1110, 4'd2, 1, 0);
    addv(143, 0, 16'h0,    4'b0000, 4'b0111, 4'd2, 1, 0);
    addv(144, 0, 16'h0,    4'b0000, 4'b0111, 4'd2, 0, 1);
    addv(145, 0, 16'h0,    4'b0000, 4'b1110, 4'd5, 0, 0);
    addv(149, 0, 16'h0,    4'b0000, 4'b1101, 4'd5, 0, 0);
    // 6666 pending, 7777 loaded on the boundary edge: 6s in frame 10, 7s in frame 11
    addv(150, 1, 16'h6666, 4'b0000, 4'b1101, 4'd5, 1, 0);
    addv(160, 1, 16'h7777, 4'b0000, 4'b0111, 4'd5, 1, 1);
    addv(161, 0, 16'h0,    4'b0000, 4'b1110, 4'd6, 1, 0);
    addv(175, 0, 16'h0,    4'b0000, 4'b0111, 4'd6, 1, 0);
    addv(176, 0, 16'h0,    4'b0000, 4'b0111, 4'd6, 0, 1);
    addv(177, 0, 16'h0,    4'b0000, 4'b1110, 4'd7, 0, 0);
    addv(192, 0, 16'h0,    4'b0000, 4'b0111, 4'd7, 0, 1);
    // 8888 pending when reset hits during the digit2 slot
    addv(195, 1, 16'h8888, 4'b0000, 4'b1110, 4'd7, 1, 0);
    addv(200, 0, 16'h0,    4'b0000, 4'b1101, 4'd7, 1, 0);
    addv(201, 0, 16'h0,    4'b0000, 4'b1011, 4'd7, 1, 0);

    rst = 1'b1;
    bus.load = 1'b0;
    bus.digits_in = '0;
    bus.blank_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    check_out("reset", SSD_OFF, CODE_BLANK, 1'b0, 1'b0);

    // Three dark frames, frame_done every 16 cycles
    for (int i = 1; i <= 48; i++) begin
      step(1'b0, 16'h0, 4'b0);
      check_out("idle", SSD_OFF, CODE_BLANK, 1'b0, (k % 16 == 0));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 16) mon_en = 1'b1;
      while (k < vecs[i].k - 1) step(1'b0, 16'h0, 4'b0);
      step(vecs[i].ld, vecs[i].dig, vecs[i].blk);
      check_out("vec", vecs[i].ssd, vecs[i].bcd, vecs[i].busy, vecs[i].fd);
    end
    mon_en = 1'b0;
    chk("no_ones_frame", 16'(ones_seen), 16'd0);

    // Asynchronous reset mid-slot: outputs clear before the next edge
    rst = 1'b1;
    #1;
    check_out("async_rst", SSD_OFF, CODE_BLANK, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    k = 0;

    step(1'b0, 16'h0, 4'b0);
    check_out("post_rst", SSD_OFF, CODE_BLANK, 1'b0, 1'b0);
    step(1'b1, 16'h0009, 4'b0000);
    check_out("post_rst_load", SSD_OFF, CODE_BLANK, 1'b1, 1'b0);
    while (k < 15) step(1'b0, 16'h0, 4'b0);
    check_out("post_rst_k15", SSD_OFF, CODE_BLANK, 1'b1, 1'b0);
    step(1'b0, 16'h0, 4'b0);
    check_out("post_rst_wrap", SSD_OFF, CODE_BLANK, 1'b0, 1'b1);
    step(1'b0, 16'h0, 4'b0);
    check_out("post_rst_d0", 4'b1110, 4'd9, 1'b0, 1'b0);
    while (k < 21) step(1'b0, 16'h0, 4'b0);
    check_out("post_rst_d1", 4'b1101, 4'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
